warp_scoreboard: RTL

//  Per-warp register-hazard scoreboard directly upstream of the warp scheduler FSM; generates its ready_mask.

---
 rtl/warp_scoreboard_if.sv | 37 +++
 rtl/warp_scoreboard.sv | 131 +++++++++++++
 2 files changed

// File: rtl/warp_scoreboard_if.sv
// rtl/warp_scoreboard_if.sv - decode/issue/writeback bundle between scheduler side and the hazard scoreboard
interface warp_scoreboard_if #(
  parameter int W    = 32,
  parameter int RIDX = 6
);
  localparam int WIDX = (W > 1) ? $clog2(W) : 1;

  logic            dec_valid;
  logic [WIDX-1:0] dec_warp;
  logic [RIDX-1:0] dec_src0;
  logic [RIDX-1:0] dec_src1;
  logic [RIDX-1:0] dec_dst;
  logic            dec_has_dst;
  logic            dec_ready;
  logic            issue_valid;
  logic [WIDX-1:0] issue_warp_id;
  logic            issue_grant_ack;
  logic            wb_valid;
  logic [WIDX-1:0] wb_warp;
  logic [RIDX-1:0] wb_reg;
  logic [W-1:0]    ready_mask;
  logic            err;

  modport master (
    output dec_valid, dec_warp, dec_src0, dec_src1, dec_dst, dec_has_dst,
    output issue_valid, issue_warp_id, issue_grant_ack,
    output wb_valid, wb_warp, wb_reg,
    input  dec_ready, ready_mask, err
  );

  modport slave (
    input  dec_valid, dec_warp, dec_src0, dec_src1, dec_dst, dec_has_dst,
    input  issue_valid, issue_warp_id, issue_grant_ack,
    input  wb_valid, wb_warp, wb_reg,
    output dec_ready, ready_mask, err
  );
endinterface

// File: rtl/warp_scoreboard.sv
// rtl/warp_scoreboard.sv - per-warp register hazard scoreboard producing the scheduler ready_mask
module warp_scoreboard #(
  parameter int W     = 32,
  parameter int RIDX  = 6,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  warp_scoreboard_if.slave sb
);
  localparam int WIDX = (W > 1) ? $clog2(W) : 1;
  localparam int KIDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // next-instruction slot per warp
  logic [W-1:0]     slot_valid;
  logic [W-1:0]     slot_has_dst;
  logic [RIDX-1:0]  slot_src0 [W];
  logic [RIDX-1:0]  slot_src1 [W];
  logic [RIDX-1:0]  slot_dst  [W];

  // in-flight destination registers per warp
  logic [DEPTH-1:0] pend_valid [W];
  logic [RIDX-1:0]  pend_reg   [W][DEPTH];

  logic             err_q;

  logic [W-1:0]     raw_hit;
  logic [W-1:0]     waw_hit;
  logic [W-1:0]     has_free;
  logic [W-1:0]     ready;

  // warp indices past W (possible only for non-power-of-two W) are rejected and steered to warp 0
  logic             dec_in, iss_in, wb_in;
  logic [WIDX-1:0]  dec_w, iss_w, wb_w;

  assign dec_in = ({1'b0, sb.dec_warp}      < (WIDX+1)'(W));
  assign iss_in = ({1'b0, sb.issue_warp_id} < (WIDX+1)'(W));
  assign wb_in  = ({1'b0, sb.wb_warp}       < (WIDX+1)'(W));
  assign dec_w  = dec_in ? sb.dec_warp      : '0;
  assign iss_w  = iss_in ? sb.issue_warp_id : '0;
  assign wb_w   = wb_in  ? sb.wb_warp       : '0;

  // hazard scan of each warp's slot against its own pending table (registered state only)
  always_comb begin
    raw_hit  = '0;
    waw_hit  = '0;
    has_free = '0;
    for (int w = 0; w < W; w++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (pend_valid[w][k]) begin
          if (pend_reg[w][k] == slot_src0[w] || pend_reg[w][k] == slot_src1[w]) raw_hit[w] = 1'b1;
          if (pend_reg[w][k] == slot_dst[w]) waw_hit[w] = 1'b1;
        end else begin
          has_free[w] = 1'b1;
        end
      end
    end
  end

  assign ready = slot_valid & ~raw_hit & (~slot_has_dst | (~waw_hit & has_free));

  logic dec_ok, fire, fire_ok, wb_ok, proto_err;
  logic            wb_hit;
  logic [KIDX-1:0] wb_idx;
  logic [KIDX-1:0] alloc_idx;

  assign sb.dec_ready  = dec_in & ~slot_valid[dec_w];
  assign sb.ready_mask = ready;
  assign sb.err        = err_q;

  assign dec_ok  = sb.dec_valid & sb.dec_ready;
  assign fire    = sb.issue_valid & sb.issue_grant_ack;
  assign fire_ok = fire & iss_in & ready[iss_w];

  // locate the pending entry a writeback retires (at most one, since WAW blocks duplicates)
  always_comb begin
    wb_hit = 1'b0;
    wb_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (pend_valid[wb_w][k] && pend_reg[wb_w][k] == sb.wb_reg) begin
        wb_hit = 1'b1;
        wb_idx = KIDX'(k);
      end
    end
  end

  assign wb_ok = sb.wb_valid & wb_in & wb_hit;

  // lowest free entry of the issuing warp, judged on occupancy before this cycle's writeback
  always_comb begin
    alloc_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!pend_valid[iss_w][k]) alloc_idx = KIDX'(k);
    end
  end

  assign proto_err = (sb.dec_valid & ~sb.dec_ready) | (fire & ~fire_ok) | (sb.wb_valid & ~wb_ok);

  // slot load / issue / writeback retirement and sticky error; a rejected event changes no state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid   <= '0;
      slot_has_dst <= '0;
      err_q        <= 1'b0;
      for (int w = 0; w < W; w++) begin
        slot_src0[w]  <= '0;
        slot_src1[w]  <= '0;
        slot_dst[w]   <= '0;
        pend_valid[w] <= '0;
        for (int k = 0; k < DEPTH; k++) pend_reg[w][k] <= '0;
      end
    end else begin
      if (dec_ok) begin
        slot_valid[dec_w]   <= 1'b1;
        slot_has_dst[dec_w] <= sb.dec_has_dst;
        slot_src0[dec_w]    <= sb.dec_src0;
        slot_src1[dec_w]    <= sb.dec_src1;
        slot_dst[dec_w]     <= sb.dec_dst;
      end
      if (fire_ok) begin
        slot_valid[iss_w] <= 1'b0;
        if (slot_has_dst[iss_w]) begin
          pend_valid[iss_w][alloc_idx] <= 1'b1;
          pend_reg[iss_w][alloc_idx]   <= slot_dst[iss_w];
        end
      end
      if (wb_ok) pend_valid[wb_w][wb_idx] <= 1'b0;
      if (proto_err) err_q <= 1'b1;
    end
  end
endmodule
